// File: rtl/regfile_pkg.sv
// Shared definitions for the writeback-arbitrated register file: register indices,
// data width, FSM state encodings and the writeback request record.
package regfile_pkg;

  localparam int DATA_W = 64;
  localparam int NREGS  = 15;

  localparam logic [3:0] RAX   = 4'd0;
  localparam logic [3:0] RCX   = 4'd1;
  localparam logic [3:0] RDX   = 4'd2;
  localparam logic [3:0] RBX   = 4'd3;
  localparam logic [3:0] RSP   = 4'd4;
  localparam logic [3:0] RBP   = 4'd5;
  localparam logic [3:0] RSI   = 4'd6;
  localparam logic [3:0] RDI   = 4'd7;
  localparam logic [3:0] R8    = 4'd8;
  localparam logic [3:0] R9    = 4'd9;
  localparam logic [3:0] R10   = 4'd10;
  localparam logic [3:0] R11   = 4'd11;
  localparam logic [3:0] R12   = 4'd12;
  localparam logic [3:0] R13   = 4'd13;
  localparam logic [3:0] R14   = 4'd14;
  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] DRAIN_M = 1'b1;

  typedef struct packed {
    logic [3:0]        dst;
    logic [DATA_W-1:0] val;
  } wb_req_t;

endpackage

// File: rtl/regfile_array.sv
// 15 x DATA_W architectural register storage: one synchronous write port and two
// asynchronous read ports; index RNONE reads as zero and swallows writes.
module regfile_array
  import regfile_pkg::*;
#(
  parameter logic [DATA_W-1:0] RSP_RESET = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [3:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        raddr_a,
  input  logic [3:0]        raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic [DATA_W-1:0] rsp_q
);

  logic [DATA_W-1:0] mem [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= (i == int'(RSP)) ? RSP_RESET : '0;
      end
    end else if (we && waddr != RNONE) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == RNONE) ? '0 : mem[raddr_a];
  assign rdata_b = (raddr_b == RNONE) ? '0 : mem[raddr_b];
  assign rsp_q   = mem[RSP];

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register file with E/M writeback arbitration (E first, M drained one cycle later)
// and a pending-write scoreboard. Optional read forwarding: REGFILE_BYPASS_EN.
module regfile_wb_ctrl
  import regfile_pkg::*;
#(
  parameter logic [DATA_W-1:0] RSP_RESET = 64'd0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        srcA,
  input  logic [3:0]        srcB,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  output logic              rd_stall,
  input  logic              e_valid,
  input  logic [3:0]        e_dst,
  input  logic [DATA_W-1:0] e_val,
  output logic              e_ready,
  input  logic              m_valid,
  input  logic [3:0]        m_dst,
  input  logic [DATA_W-1:0] m_val,
  output logic              m_ready,
  output logic              busy,
  output logic [DATA_W-1:0] rsp_dbg
);

  // Handshake: a request is taken on a rising edge where valid && ready. Both
  // readies drop together for the single DRAIN_M cycle; requesters must hold.

  logic [0:0]        state;
  wb_req_t           hold;
  // Bit 15 (RNONE) is never set, so a 4-bit index can address it safely.
  logic [15:0]       pending;
  logic              wr_en;
  logic [3:0]        wr_dst;
  logic [DATA_W-1:0] wr_val;
  logic [DATA_W-1:0] arr_a;
  logic [DATA_W-1:0] arr_b;

  assign e_ready = (state == IDLE);
  assign m_ready = (state == IDLE);
  assign busy    = (state == DRAIN_M);

  always_comb begin
    wr_en  = 1'b0;
    wr_dst = RNONE;
    wr_val = '0;
    if (state == DRAIN_M) begin
      wr_en  = 1'b1;
      wr_dst = hold.dst;
      wr_val = hold.val;
    end else if (e_valid) begin
      wr_en  = 1'b1;
      wr_dst = e_dst;
      wr_val = e_val;
    end else if (m_valid) begin
      wr_en  = 1'b1;
      wr_dst = m_dst;
      wr_val = m_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      hold    <= '{dst: RNONE, val: '0};
      pending <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (e_valid && m_valid) begin
            hold <= '{dst: m_dst, val: m_val};
            if (m_dst != RNONE) pending[m_dst] <= 1'b1;
            state <= DRAIN_M;
          end
        end
        DRAIN_M: begin
          pending[hold.dst] <= 1'b0;
          state             <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  regfile_array #(.RSP_RESET(RSP_RESET)) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wr_en),
    .waddr   (wr_dst),
    .wdata   (wr_val),
    .raddr_a (srcA),
    .raddr_b (srcB),
    .rdata_a (arr_a),
    .rdata_b (arr_b),
    .rsp_q   (rsp_dbg)
  );

`ifdef REGFILE_BYPASS_EN
  // In IDLE the M value wins a same-index tie because it lands last.
  always_comb begin
    valA = arr_a;
    valB = arr_b;
    if (srcA != RNONE) begin
      if (state == DRAIN_M) begin
        if (pending[srcA]) valA = hold.val;
      end else if (m_valid && srcA == m_dst) begin
        valA = m_val;
      end else if (e_valid && srcA == e_dst) begin
        valA = e_val;
      end
    end
    if (srcB != RNONE) begin
      if (state == DRAIN_M) begin
        if (pending[srcB]) valB = hold.val;
      end else if (m_valid && srcB == m_dst) begin
        valB = m_val;
      end else if (e_valid && srcB == e_dst) begin
        valB = e_val;
      end
    end
  end
  assign rd_stall = 1'b0;
`else
  assign valA     = arr_a;
  assign valB     = arr_b;
  assign rd_stall = pending[srcA] | pending[srcB];
`endif

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: directed cases followed by random
// writeback/read traffic against an array-based reference model.
module tb_regfile_wb_ctrl;
  import regfile_pkg::*;

  localparam logic [63:0] RSP_INIT = 64'h100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  src_a, src_b;
  logic [63:0] val_a, val_b;
  logic        rd_stall;
  logic        e_valid, m_valid;
  logic [3:0]  e_dst, m_dst;
  logic [63:0] e_val, m_val;
  logic        e_ready, m_ready, busy;
  logic [63:0] rsp_dbg;

  always #5 clk = ~clk;

  regfile_wb_ctrl #(.RSP_RESET(RSP_INIT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .srcA     (src_a),
    .srcB     (src_b),
    .valA     (val_a),
    .valB     (val_b),
    .rd_stall (rd_stall),
    .e_valid  (e_valid),
    .e_dst    (e_dst),
    .e_val    (e_val),
    .e_ready  (e_ready),
    .m_valid  (m_valid),
    .m_dst    (m_dst),
    .m_val    (m_val),
    .m_ready  (m_ready),
    .busy     (busy),
    .rsp_dbg  (rsp_dbg)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0] exp_q[$];

  // Reference model: plain register array plus one outstanding M write.
  logic [63:0] ref_regs [15];
  bit          ref_drain;
  logic [3:0]  ref_hdst;
  logic [63:0] ref_hval;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic ref_reset();
    for (int i = 0; i < 15; i++) ref_regs[i] = 64'd0;
    ref_regs[4] = RSP_INIT;
    ref_drain   = 1'b0;
    ref_hdst    = 4'hF;
    ref_hval    = 64'd0;
  endtask

  task automatic ref_write(input logic [3:0] d, input logic [63:0] v);
    if (d != 4'hF) ref_regs[d] = v;
  endtask

  task automatic ref_step();
    if (ref_drain) begin
      ref_write(ref_hdst, ref_hval);
      ref_drain = 1'b0;
    end else if (e_valid && m_valid) begin
      ref_write(e_dst, e_val);
      ref_hdst  = m_dst;
      ref_hval  = m_val;
      ref_drain = 1'b1;
    end else if (e_valid) begin
      ref_write(e_dst, e_val);
    end else if (m_valid) begin
      ref_write(m_dst, m_val);
    end
  endtask

  function automatic logic [63:0] ref_read(input logic [3:0] src);
    if (src == 4'hF) return 64'd0;
`ifdef REGFILE_BYPASS_EN
    if (ref_drain) begin
      if (src == ref_hdst) return ref_hval;
    end else if (m_valid && src == m_dst) begin
      return m_val;
    end else if (e_valid && src == e_dst) begin
      return e_val;
    end
`endif
    return ref_regs[src];
  endfunction

  function automatic logic ref_stall();
`ifdef REGFILE_BYPASS_EN
    return 1'b0;
`else
    return ref_drain && ref_hdst != 4'hF && (src_a == ref_hdst || src_b == ref_hdst);
`endif
  endfunction

  task automatic set_in(input logic ev, input logic [3:0] ed, input logic [63:0] ex,
                        input logic mv, input logic [3:0] md, input logic [63:0] mx,
                        input logic [3:0] sa, input logic [3:0] sb);
    e_valid = ev; e_dst = ed; e_val = ex;
    m_valid = mv; m_dst = md; m_val = mx;
    src_a   = sa; src_b = sb;
  endtask

  task automatic sample();
    @(negedge clk);
    exp_q.push_back(ref_read(src_a));
    exp_q.push_back(ref_read(src_b));
    exp_q.push_back(ref_regs[4]);
    check("valA", val_a, exp_q.pop_front());
    check("valB", val_b, exp_q.pop_front());
    check("rsp_dbg", rsp_dbg, exp_q.pop_front());
    check("rd_stall", {63'd0, rd_stall}, {63'd0, ref_stall()});
    check("e_ready", {63'd0, e_ready}, {63'd0, !ref_drain});
    check("m_ready", {63'd0, m_ready}, {63'd0, !ref_drain});
    check("busy", {63'd0, busy}, {63'd0, ref_drain});
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst_n) ref_step();
    #1;
  endtask

  initial begin
    ref_reset();
    set_in(0, 4'd0, 64'd0, 0, 4'd0, 64'd0, 4'd4, 4'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    sample();
    check("rst_rsp", val_a, 64'h100);
    check("rst_r0", val_b, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_ready", {62'd0, e_ready, m_ready}, 64'd3);
    advance();

    // E only
    set_in(1, 4'd2, 64'hDEAD, 0, 4'd0, 64'd0, 4'd2, 4'hF);
    sample(); advance();
    set_in(0, 4'd0, 64'd0, 0, 4'd0, 64'd0, 4'd2, 4'd4);
    sample();
    check("e_only_val", val_a, 64'hDEAD);
    check("e_only_busy", {63'd0, busy}, 64'd0);
    advance();

    // Dual request, different destinations
    set_in(1, 4'd1, 64'd5, 1, 4'd3, 64'd7, 4'd1, 4'd3);
    sample(); advance();
    set_in(0, 4'd0, 64'd0, 0, 4'd0, 64'd0, 4'd1, 4'd3);
    sample();
    check("dual_reg1", val_a, 64'd5);
    check("dual_busy", {63'd0, busy}, 64'd1);
    check("dual_ready", {62'd0, e_ready, m_ready}, 64'd0);
`ifdef REGFILE_BYPASS_EN
    check("dual_fwd_valB", val_b, 64'd7);
    check("dual_stall", {63'd0, rd_stall}, 64'd0);
`else
    check("dual_stall", {63'd0, rd_stall}, 64'd1);
`endif
    advance();
    set_in(0, 4'd0, 64'd0, 0, 4'd0, 64'd0, 4'd3, 4'd3);
    sample();
    check("dual_reg3", val_a, 64'd7);
    check("dual_done_stall", {63'd0, rd_stall}, 64'd0);
    check("dual_done_busy", {63'd0, busy}, 64'd0);
    advance();

    // Dual request, same destination rsp: M lands last
    set_in(1, 4'd4, 64'h108, 1, 4'd4, 64'h50, 4'd4, 4'd0);
    sample(); advance();
    set_in(0, 4'd0, 64'd0, 0, 4'd0, 64'd0, 4'd4, 4'd0);
    sample(); advance();
    sample();
    check("same_dst_rsp", rsp_dbg, 64'h50);
    advance();

    // RNONE writes and reads
    set_in(1, 4'hF, 64'hAAAA, 1, 4'hF, 64'hBBBB, 4'hF, 4'hF);
    sample();
    check("rnone_val", val_a, 64'd0);
    advance();
    set_in(0, 4'd0, 64'd0, 0, 4'd0, 64'd0, 4'hF, 4'd4);
    sample();
    check("rnone_busy", {63'd0, busy}, 64'd1);
    check("rnone_stall", {63'd0, rd_stall}, 64'd0);
    advance();
    set_in(1, 4'hF, 64'hCC, 0, 4'd0, 64'd0, 4'hF, 4'd4);
    sample(); advance();
    set_in(0, 4'd0, 64'd0, 0, 4'd0, 64'd0, 4'hF, 4'd4);
    sample();
    check("rnone_rsp", rsp_dbg, 64'h50);
    check("rnone_r4", val_b, 64'h50);
    advance();

    // Reset in the middle of DRAIN_M
    set_in(1, 4'd1, 64'd11, 1, 4'd6, 64'd9, 4'd6, 4'd1);
    sample(); advance();
    set_in(0, 4'd0, 64'd0, 0, 4'd0, 64'd0, 4'd6, 4'd1);
    sample();
    rst_n = 1'b0;
    ref_reset();
    #1;
    check("rstmid_reg6", val_a, 64'd0);
    check("rstmid_reg1", val_b, 64'd0);
    check("rstmid_busy", {63'd0, busy}, 64'd0);
    check("rstmid_stall", {63'd0, rd_stall}, 64'd0);
    check("rstmid_rsp", rsp_dbg, RSP_INIT);
    @(posedge clk);
    #1 rst_n = 1'b1;
    sample();
    check("rstmid_after_reg6", val_a, 64'd0);
    advance();

    // Random traffic
    repeat (400) begin
      set_in(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), {$urandom, $urandom},
             1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), {$urandom, $urandom},
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      sample();
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
- Owns the 15-entry x 64-bit architectural register file (rax..r14) and arbitrates its single physical write port between the two writeback sources: E (ALU result, dstE/valE) and M (memory result, dstM/valM).
- Serves the decode stage's two combinational read ports (srcA/srcB) and raises a stall when a read targets a register with a write still in flight.
- Sits between the decode and writeback stages and replaces the flat per-register inputs that decode consumes today.

Parameters:
- DATA_W, 64, register width.
- NREGS, 15, number of architectural registers, indices 0..14.
- RNONE, 4'hF, "no register" encoding.
- RSP_RESET, 64'd0, reset value of register 4 (rsp); all other registers reset to 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- srcA  in  4  read port A index.
- srcB  in  4  read port B index.
- valA  out  DATA_W  read data A (combinational).
- valB  out  DATA_W  read data B (combinational).
- rd_stall  out  1  a read hits a pending register; decode must hold.
- e_valid  in  1  E writeback request.
- e_dst  in  4  E destination.
- e_val  in  DATA_W  E data.
- e_ready  out  1  E request accepted this cycle.
- m_valid  in  1  M writeback request.
- m_dst  in  4  M destination.
- m_val  in  DATA_W  M data.
- m_ready  out  1  M request accepted this cycle.
- busy  out  1  FSM in DRAIN_M.
- rsp_dbg  out  DATA_W  current rsp, for the testbench.

Behaviour:
- Reset (async assert, sync release): all registers 0 except rsp = RSP_RESET, FSM = IDLE, hold register cleared, pending scoreboard all 0, busy = 0, e_ready = m_ready = 1.
- Reads: valX = reg[srcX] for srcX 0..14; srcX = RNONE returns 0 and never stalls. Reads see the register contents before this cycle's write, with no write-through.
- Writes to dst = RNONE are accepted and discarded, and never set a pending bit.
- FSM IDLE: e_ready = m_ready = 1.
  - Only E valid: write reg[e_dst] = e_val at the clock edge; stay IDLE.
  - Only M valid: write reg[m_dst] = m_val; stay IDLE.
  - Both valid: write E this edge, latch (m_dst, m_val) into the hold register, set pending[m_dst] (if not RNONE), go to DRAIN_M.
  - Ordering is fixed as E then M, so on e_dst == m_dst the M value is final (popq %rsp semantics).
- FSM DRAIN_M: e_ready = m_ready = 0 and busy = 1. New requests are not accepted; requesters hold.
  - At the edge: write the held M, clear its pending bit, return to IDLE.
  - Latency is always exactly one extra cycle.
- rd_stall = (srcA != RNONE && pending[srcA]) || (srcB != RNONE && pending[srcB]). In IDLE, pending is all 0, so rd_stall = 0.
- Both sources valid with both dst = RNONE: take the same path as any dual request (DRAIN_M cycle still taken), with no register change.
- Reset mid-DRAIN_M: the held write is dropped, the scoreboard is cleared, and the register file is reinitialised.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Read ports forward in-flight data. A read of the register being written this cycle returns the write data (E in IDLE, held M in DRAIN_M, M priority if both match).
  - A read of pending[srcX] returns the held m_val.
  - rd_stall is tied to 0.
- Undefined: behaviour as above (no forwarding, stall on pending).

Decomposition:
- Shared package regfile_pkg:
  - register index constants RAX=0..R14=14, RSP=4, RNONE=4'hF.
  - DATA_W.
  - FSM state enum {IDLE, DRAIN_M}.
  - struct wb_req_t {dst, val}.
- One sub-module, regfile_array: 15 x DATA_W storage, one synchronous write port, two async read ports, RNONE handling, async reset.
- regfile_wb_ctrl holds the FSM, hold register, scoreboard and bypass mux.

Test Plan:
- Reset with RSP_RESET = 64'h100; read srcA = 4, srcB = 0 -> valA = 64'h100, valB = 0, e_ready = m_ready = 1, busy = 0.
- E only: e_dst = 2, e_val = 64'hDEAD for 1 cycle; next cycle srcA = 2 -> valA = 64'hDEAD, no busy.
- Dual, different dst: e_dst = 1/5, m_dst = 3/7 in one cycle. Cycle +1: reg1 = 5, busy = 1, ready = 0, srcB = 3 -> rd_stall = 1 (no bypass). Cycle +2: reg3 = 7, rd_stall = 0, busy = 0.
- Dual, same dst 4 (E = 64'h108, M = 64'h50) -> after 2 cycles rsp_dbg = 64'h50.
- Writes with dst = RNONE and reads of srcA = RNONE -> no register changes, valA = 0, rd_stall = 0.
- rst_n asserted during DRAIN_M (held m_dst = 6, value 9) -> reg6 = 0, pending cleared, FSM IDLE; repeat the dual-request case with REGFILE_BYPASS_EN -> valB = 7, rd_stall = 0 in cycle +1.
